crv32_dbg_loader: RTL



---
 rtl/crv32_dbg_loader.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/crv32_dbg_loader.sv
// crv32_dbg_loader: parses the host UART byte-command stream and drives the SoC debug memory port and CPU reset.
// Optional feature: define CRV32_DBG_LOADER_READ_EN to build the 'R' word-read command and its 4-byte reply path.
module crv32_dbg_loader #(
  parameter int unsigned ACCESS_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter bit          RESET_HALTED   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        dbg_mem_op,
  output logic [3:0]  dbg_wren,
  output logic [31:0] dbg_adr,
  output logic [31:0] dbg_do,
  input  logic [31:0] dbg_di,
  output logic        cpu_n_reset
);

  localparam int unsigned ACW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int unsigned TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_H = 8'h48;
  localparam logic [7:0] OP_G = 8'h47;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;
`ifdef CRV32_DBG_LOADER_READ_EN
  localparam logic [7:0] OP_R = 8'h52;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic            op_wr_q, op_wr_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [ACW-1:0]  acc_cnt_q, acc_cnt_d;
  logic [TOW-1:0]  to_cnt_q, to_cnt_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            dbg_mem_op_q, dbg_mem_op_d;
  logic [3:0]      dbg_wren_q, dbg_wren_d;
  logic [31:0]     dbg_adr_q, dbg_adr_d;
  logic [31:0]     dbg_do_q, dbg_do_d;
  logic            cpu_n_reset_q, cpu_n_reset_d;
  logic            timeout;

`ifdef CRV32_DBG_LOADER_READ_EN
  logic [23:0]     rdata_q, rdata_d;
  logic [1:0]      resp_left_q, resp_left_d;
`else
  logic            unused_dbg_di;
  assign unused_dbg_di = ^dbg_di;
`endif

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign dbg_mem_op  = dbg_mem_op_q;
  assign dbg_wren    = dbg_wren_q;
  assign dbg_adr     = dbg_adr_q;
  assign dbg_do      = dbg_do_q;
  assign cpu_n_reset = cpu_n_reset_q;

  // Command parser, bus sequencer and reply generator.
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    op_wr_d       = op_wr_q;
    addr_d        = addr_q;
    data_d        = data_q;
    acc_cnt_d     = acc_cnt_q;
    to_cnt_d      = to_cnt_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    dbg_mem_op_d  = 1'b0;
    dbg_wren_d    = 4'h0;
    dbg_adr_d     = dbg_adr_q;
    dbg_do_d      = dbg_do_q;
    cpu_n_reset_d = cpu_n_reset_q;
`ifdef CRV32_DBG_LOADER_READ_EN
    rdata_d       = rdata_q;
    resp_left_d   = resp_left_q;
`endif
    timeout       = (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1));

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          byte_cnt_d = 2'd0;
          to_cnt_d   = '0;
          case (rx_data)
            OP_W: begin
              op_wr_d = 1'b1;
              state_d = S_ADDR;
            end
`ifdef CRV32_DBG_LOADER_READ_EN
            OP_R: begin
              op_wr_d = 1'b0;
              state_d = S_ADDR;
            end
`endif
            OP_H: begin
              cpu_n_reset_d = 1'b0;
              tx_valid_d    = 1'b1;
              tx_data_d     = ACK;
              state_d       = S_RESP;
            end
            OP_G: begin
              cpu_n_reset_d = 1'b1;
              tx_valid_d    = 1'b1;
              tx_data_d     = ACK;
              state_d       = S_RESP;
            end
            default: begin
              tx_valid_d = 1'b1;
              tx_data_d  = NAK;
              state_d    = S_RESP;
            end
          endcase
        end
      end

      S_ADDR: begin
        // Timeout takes priority over a byte arriving in the same cycle.
        if (timeout) begin
          state_d = S_IDLE;
        end else if (rx_valid) begin
          to_cnt_d   = '0;
          addr_d     = {rx_data, addr_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (op_wr_q) begin
              state_d = S_DATA;
            end else if (cpu_n_reset_q) begin
              tx_valid_d = 1'b1;
              tx_data_d  = NAK;
              state_d    = S_RESP;
            end else begin
              acc_cnt_d    = '0;
              dbg_mem_op_d = 1'b1;
              dbg_adr_d    = {rx_data, addr_q[31:8]};
              state_d      = S_ACCESS;
            end
          end
        end else begin
          to_cnt_d = to_cnt_q + TOW'(1);
        end
      end

      S_DATA: begin
        if (timeout) begin
          state_d = S_IDLE;
        end else if (rx_valid) begin
          to_cnt_d   = '0;
          data_d     = {rx_data, data_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (cpu_n_reset_q) begin
              tx_valid_d = 1'b1;
              tx_data_d  = NAK;
              state_d    = S_RESP;
            end else begin
              acc_cnt_d    = '0;
              dbg_mem_op_d = 1'b1;
              dbg_wren_d   = 4'hF;
              dbg_adr_d    = addr_q;
              dbg_do_d     = {rx_data, data_q[31:8]};
              state_d      = S_ACCESS;
            end
          end
        end else begin
          to_cnt_d = to_cnt_q + TOW'(1);
        end
      end

      S_ACCESS: begin
        if (acc_cnt_q == ACW'(ACCESS_CYCLES - 1)) begin
          tx_valid_d = 1'b1;
          tx_data_d  = ACK;
          state_d    = S_RESP;
`ifdef CRV32_DBG_LOADER_READ_EN
          // Read data is sampled on the final access cycle; byte 0 goes out directly.
          if (!op_wr_q) begin
            tx_data_d   = dbg_di[7:0];
            rdata_d     = dbg_di[31:8];
            resp_left_d = 2'd3;
          end
`endif
        end else begin
          acc_cnt_d    = acc_cnt_q + ACW'(1);
          dbg_mem_op_d = 1'b1;
          dbg_wren_d   = op_wr_q ? 4'hF : 4'h0;
        end
      end

      S_RESP: begin
        if (tx_ready) begin
`ifdef CRV32_DBG_LOADER_READ_EN
          if (resp_left_q != 2'd0) begin
            tx_data_d   = rdata_q[7:0];
            rdata_d     = {8'h00, rdata_q[23:8]};
            resp_left_d = resp_left_q - 2'd1;
          end else
`endif
          begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      byte_cnt_q    <= 2'd0;
      op_wr_q       <= 1'b0;
      addr_q        <= 32'h0;
      data_q        <= 32'h0;
      acc_cnt_q     <= '0;
      to_cnt_q      <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      dbg_mem_op_q  <= 1'b0;
      dbg_wren_q    <= 4'h0;
      dbg_adr_q     <= 32'h0;
      dbg_do_q      <= 32'h0;
      cpu_n_reset_q <= ~RESET_HALTED;
`ifdef CRV32_DBG_LOADER_READ_EN
      rdata_q       <= 24'h0;
      resp_left_q   <= 2'd0;
`endif
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      op_wr_q       <= op_wr_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      acc_cnt_q     <= acc_cnt_d;
      to_cnt_q      <= to_cnt_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      dbg_mem_op_q  <= dbg_mem_op_d;
      dbg_wren_q    <= dbg_wren_d;
      dbg_adr_q     <= dbg_adr_d;
      dbg_do_q      <= dbg_do_d;
      cpu_n_reset_q <= cpu_n_reset_d;
`ifdef CRV32_DBG_LOADER_READ_EN
      rdata_q       <= rdata_d;
      resp_left_q   <= resp_left_d;
`endif
    end
  end

endmodule
